// File: rtl/tcm_pkg.sv
// tcm_pkg: shared opcodes, field positions, core states and memory depth for the two-counter machine
package tcm_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_CLR, OP_INC, OP_DEC, OP_CPY, OP_JMPZ, OP_JMPE, OP_HALT} op_e;
  typedef enum logic [1:0] {S_EXEC, S_HALT, S_FAULT} state_e;
  localparam int OP_HI = 7;
  localparam int OP_LO = 5;
  localparam int RX_BIT = 4;
  localparam int RY_BIT = 3;
  localparam int OFF4_HI = 3;
  localparam int OFF3_HI = 2;
  localparam int IMEM_DEPTH = 128;
endpackage

// File: rtl/tcm_decode.sv
// tcm_decode: splits an instruction word into opcode, register selects and a sign-extended PC offset
module tcm_decode
  import tcm_pkg::*;
(
  input  logic [7:0] instr,
  output op_e        op,
  output logic       rx,
  output logic       ry,
  output logic [7:0] off
);
  // ry is the explicit second operand for JMPE and the other counter for everything else (CPY source)
  always_comb begin
    op = op_e'(instr[OP_HI:OP_LO]);
    rx = instr[RX_BIT];
    ry = op == OP_JMPE ? instr[RY_BIT] : ~instr[RX_BIT];
    off = op == OP_JMPE ? {{5{instr[OFF3_HI]}}, instr[OFF3_HI:0]} : {{4{instr[OFF4_HI]}}, instr[OFF4_HI:0]};
  end
endmodule

// File: rtl/tcm_exec.sv
// tcm_exec: single-issue fetch/execute core running one two-counter instruction per cycle
module tcm_exec
  import tcm_pkg::*;
#(
  parameter int W = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [7:0]       ADDR,
  input  logic [7:0]       INSTR,
  input  logic             RUN,
  output logic [W-1:0]     REG_A,
  output logic [W-1:0]     REG_B,
  output logic             HALTED,
  output logic             FAULT,
  output logic             OVF,
  output logic [CNT_W-1:0] RETIRED
);
  op_e op;
  state_e state;
  logic rx, ry, sat, zero, take, flt;
  logic [7:0] off, npc;
  logic [W-1:0] cur, oth, nxt;
  tcm_decode u_dec (.instr(INSTR), .op(op), .rx(rx), .ry(ry), .off(off));
  // next value of the addressed counter and the next PC, all from pre-edge state
  always_comb begin
    cur = rx ? REG_B : REG_A;
    oth = ry ? REG_B : REG_A;
    sat = &cur;
    zero = cur == '0;
    nxt = op == OP_CLR ? '0 :
          op == OP_INC ? (sat ? cur : cur + W'(1)) :
          op == OP_DEC ? (zero ? cur : cur - W'(1)) :
          op == OP_CPY ? oth : cur;
    take = (op == OP_JMPZ && zero) || (op == OP_JMPE && cur == oth);
    npc = ADDR + (take ? off : 8'd1);
    flt = npc >= 8'(IMEM_DEPTH);
  end
  // core FSM: retire one instruction per enabled EXEC cycle; a faulting instruction still commits its register effects
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_EXEC;
      ADDR <= '0;
      REG_A <= '0;
      REG_B <= '0;
      HALTED <= 1'b0;
      FAULT <= 1'b0;
      OVF <= 1'b0;
      RETIRED <= '0;
    end else if (RUN && state == S_EXEC) begin
      if (rx) REG_B <= nxt;
      else REG_A <= nxt;
      OVF <= OVF | (op == OP_INC && sat);
      RETIRED <= &RETIRED ? RETIRED : RETIRED + CNT_W'(1);
      state <= op == OP_HALT ? S_HALT : flt ? S_FAULT : S_EXEC;
      HALTED <= op == OP_HALT || flt;
      FAULT <= op != OP_HALT && flt;
      ADDR <= (op == OP_HALT || flt) ? ADDR : npc;
    end
  end
endmodule

// File: tb/tb_tcm_exec.sv
// tb_tcm_exec: directed and random programs checked every cycle against a behavioural model of the machine
module tb_tcm_exec;
  localparam int W = 4;
  localparam int CNT_W = 8;
  localparam int MX = (1 << W) - 1;
  logic clk = 0;
  logic rst = 1;
  logic run = 0;
  logic [7:0] addr;
  logic [7:0] mem [256];
  logic [W-1:0] reg_a, reg_b;
  logic halted, fault, ovf;
  logic [CNT_W-1:0] retired;
  int vectors = 0;
  int errs = 0;
  int m_pc = 0, m_a = 0, m_b = 0, m_ovf = 0, m_halt = 0, m_fault = 0, m_ret = 0;
  always #5 clk = ~clk;
  tcm_exec #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RESET(rst), .ADDR(addr), .INSTR(mem[addr]), .RUN(run),
    .REG_A(reg_a), .REG_B(reg_b), .HALTED(halted), .FAULT(fault), .OVF(ovf), .RETIRED(retired)
  );
  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
    end
  endtask
  // behavioural reference: interpret the instruction at the model PC with plain integer arithmetic
  always @(posedge clk) begin : model
    int op, r, npc;
    int rg[2];
    int old[2];
    logic [7:0] ins;
    if (rst) begin
      m_pc = 0; m_a = 0; m_b = 0; m_ovf = 0; m_halt = 0; m_fault = 0; m_ret = 0;
    end else if (run && !m_halt) begin
      ins = mem[m_pc];
      op = int'(ins[7:5]);
      r = int'(ins[4]);
      rg[0] = m_a; rg[1] = m_b;
      old = rg;
      npc = m_pc + 1;
      case (op)
        1: rg[r] = 0;
        2: if (rg[r] == MX) m_ovf = 1; else rg[r] = rg[r] + 1;
        3: if (rg[r] > 0) rg[r] = rg[r] - 1;
        4: rg[r] = old[1 - r];
        5: if (old[r] == 0) npc = m_pc + (int'(ins[3:0]) ^ 8) - 8;
        6: if (old[r] == old[int'(ins[3])]) npc = m_pc + (int'(ins[2:0]) ^ 4) - 4;
        default: ;
      endcase
      npc = npc & 255;
      m_a = rg[0]; m_b = rg[1];
      m_ret = m_ret < 255 ? m_ret + 1 : 255;
      if (op == 7) m_halt = 1;
      else if (npc >= 128) begin m_halt = 1; m_fault = 1; end
      else m_pc = npc;
    end
  end
  // every-cycle comparison away from the active edge
  always @(negedge clk) begin
    cmp("addr", 32'(addr), 32'(m_pc));
    cmp("reg_a", 32'(reg_a), 32'(m_a));
    cmp("reg_b", 32'(reg_b), 32'(m_b));
    cmp("halted", 32'(halted), 32'(m_halt));
    cmp("fault", 32'(fault), 32'(m_fault));
    cmp("ovf", 32'(ovf), 32'(m_ovf));
    cmp("retired", 32'(retired), 32'(m_ret));
  end
  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic hold_reset();
    rst = 1;
    run = 1;
    tick(1);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask
  task automatic go();
    tick(1);
    rst = 0;
  endtask
  task automatic load_demo();
    for (int i = 0; i < 5; i++) mem[i] = 8'h40;
    mem[5] = 8'h50; mem[6] = 8'h50; mem[7] = 8'hB4; mem[8] = 8'h70; mem[9] = 8'h60;
    mem[10] = 8'hC5; mem[11] = 8'h90; mem[12] = 8'h30; mem[13] = 8'hE0;
  endtask
  task automatic check_demo(string n);
    cmp({n, "_halted"}, 32'(halted), 1);
    cmp({n, "_retired"}, 32'(retired), 19);
    cmp({n, "_a"}, 32'(reg_a), 3);
    cmp({n, "_b"}, 32'(reg_b), 0);
    cmp({n, "_addr"}, 32'(addr), 13);
    cmp({n, "_fault"}, 32'(fault), 0);
    cmp({n, "_ovf"}, 32'(ovf), 0);
  endtask
  initial begin
    logic [7:0] v;
    tick(2);
    hold_reset();
    load_demo();
    tick(1);
    cmp("rst_addr", 32'(addr), 0);
    cmp("rst_retired", 32'(retired), 0);
    cmp("rst_halted", 32'(halted), 0);
    go();
    tick(25);
    check_demo("demo");
    hold_reset();
    load_demo();
    go();
    tick(12);
    rst = 1;
    tick(1);
    cmp("midrst_addr", 32'(addr), 0);
    cmp("midrst_a", 32'(reg_a), 0);
    cmp("midrst_b", 32'(reg_b), 0);
    cmp("midrst_retired", 32'(retired), 0);
    rst = 0;
    tick(25);
    check_demo("rerun");
    hold_reset();
    load_demo();
    go();
    tick(9);
    run = 0;
    tick(5);
    run = 1;
    tick(25);
    check_demo("gated");
    hold_reset();
    mem[0] = 8'h60;
    for (int i = 1; i <= 16; i++) mem[i] = 8'h40;
    mem[17] = 8'h20; mem[18] = 8'hE0;
    go();
    tick(16);
    cmp("sat15_a", 32'(reg_a), 15);
    cmp("sat15_ovf", 32'(ovf), 0);
    tick(1);
    cmp("sat16_a", 32'(reg_a), 15);
    cmp("sat16_ovf", 32'(ovf), 1);
    tick(5);
    cmp("satclr_a", 32'(reg_a), 0);
    cmp("satclr_ovf", 32'(ovf), 1);
    cmp("satclr_retired", 32'(retired), 19);
    hold_reset();
    mem[124] = 8'hA7;
    go();
    tick(130);
    cmp("flt_fault", 32'(fault), 1);
    cmp("flt_halted", 32'(halted), 1);
    cmp("flt_addr", 32'(addr), 124);
    cmp("flt_retired", 32'(retired), 125);
    tick(3);
    cmp("flt_frozen", 32'(retired), 125);
    hold_reset();
    mem[3] = 8'hA8;
    go();
    tick(10);
    cmp("wrap_fault", 32'(fault), 1);
    cmp("wrap_addr", 32'(addr), 3);
    cmp("wrap_retired", 32'(retired), 4);
    hold_reset();
    mem[0] = 8'h40; mem[1] = 8'hCC; mem[2] = 8'hE0;
    go();
    tick(6);
    cmp("jmpe_addr", 32'(addr), 2);
    cmp("jmpe_fault", 32'(fault), 0);
    cmp("jmpe_halted", 32'(halted), 1);
    cmp("jmpe_retired", 32'(retired), 3);
    for (int p = 0; p < 30; p++) begin
      hold_reset();
      for (int i = 0; i < 128; i++) begin
        v = 8'($urandom);
        if (v[7:5] == 3'd7 && $urandom_range(3) != 0) v[7:5] = 3'd2;
        mem[i] = v;
      end
      go();
      repeat (200) begin
        run = $urandom_range(3) != 0;
        rst = $urandom_range(63) == 0;
        tick(1);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
